// File: rtl/sdram_defs.sv
// Shared SDRAM definitions: command encodings, all-bank address, refresh FSM states.
// Used by the arbiter and by the init, write, read and auto-refresh controllers.
package sdram_defs;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  // A10=1 selects all-bank precharge
  localparam logic [1:0]  ALL_BANK_BA   = 2'b11;
  localparam logic [12:0] ALL_BANK_ADDR = 13'h1fff;

  typedef enum logic [2:0] {
    AREF_IDLE,
    AREF_PCHA,
    AREF_TRP,
    AREF_AREF,
    AREF_TRF,
    AREF_END
  } aref_state_t;

endpackage

// File: rtl/sdram_aref_ctrl_if.sv
// Auto-refresh controller <-> arbiter bundle.
// Optional aref_miss_cnt exists only with SDRAM_AREF_MISS_CNT_EN.
interface sdram_aref_ctrl_if;
  logic        aref_en;
  logic        aref_req;
  logic        aref_end;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;
`ifdef SDRAM_AREF_MISS_CNT_EN
  logic [7:0]  aref_miss_cnt;

  modport master (
    input  aref_en,
    output aref_req, aref_end,
    output aref_cmd, aref_ba, aref_addr,
    output aref_miss_cnt
  );

  modport slave (
    output aref_en,
    input  aref_req, aref_end,
    input  aref_cmd, aref_ba, aref_addr,
    input  aref_miss_cnt
  );
`else
  modport master (
    input  aref_en,
    output aref_req, aref_end,
    output aref_cmd, aref_ba, aref_addr
  );

  modport slave (
    output aref_en,
    input  aref_req, aref_end,
    input  aref_cmd, aref_ba, aref_addr
  );
`endif
endinterface

// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh controller: interval timer, request, PRE-all + N x AREF.
// Optional starvation counter aref_miss_cnt: define SDRAM_AREF_MISS_CNT_EN.
module sdram_aref_ctrl #(
  parameter int CNT_REF_MAX = 1250,
  parameter int TRP_CLK     = 3,
  parameter int TRC_CLK     = 10,
  parameter int AREF_NUM    = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  sdram_aref_ctrl_if.master bus
);
  import sdram_defs::*;

  localparam int CW   = $clog2(CNT_REF_MAX);
  localparam int WMAX = (TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK;
  localparam int WW   = $clog2(WMAX + 1);
  localparam int RW   = 3;

  logic [CW-1:0] cnt_ref;
  logic          wrap;
  logic          req_q;

  aref_state_t   st_q, st_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          end_q, end_d;

  assign wrap = init_end && (cnt_ref == CW'(CNT_REF_MAX - 1));

  // free-running refresh interval, held while init is pending
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  cnt_ref <= '0;
    else if (!init_end) cnt_ref <= '0;
    else if (wrap)   cnt_ref <= '0;
    else             cnt_ref <= cnt_ref + CW'(1);
  end

  // request: a new interval wins over a same-edge grant
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     req_q <= 1'b0;
    else if (!init_end) req_q <= 1'b0;
    else if (wrap)      req_q <= 1'b1;
    else if (st_q == AREF_IDLE && bus.aref_en)
      req_q <= 1'b0;
  end

  // state, timers and registered command
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_q   <= AREF_IDLE;
      wait_q <= '0;
      ref_q  <= '0;
      cmd_q  <= CMD_NOP;
      end_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      wait_q <= wait_d;
      ref_q  <= ref_d;
      cmd_q  <= cmd_d;
      end_q  <= end_d;
    end
  end

  // next state; command decoded from the next state so it aligns with st_q
  always_comb begin
    st_d   = st_q;
    wait_d = wait_q;
    ref_d  = ref_q;
    cmd_d  = CMD_NOP;
    end_d  = 1'b0;
    unique case (st_q)
      AREF_IDLE: if (bus.aref_en) st_d = AREF_PCHA;
      AREF_PCHA: begin
        st_d   = AREF_TRP;
        wait_d = '0;
      end
      AREF_TRP: begin
        if (wait_q == WW'(TRP_CLK - 1)) begin
          st_d   = AREF_AREF;
          wait_d = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      AREF_AREF: begin
        st_d   = AREF_TRF;
        wait_d = '0;
        ref_d  = ref_q + RW'(1);
      end
      AREF_TRF: begin
        if (wait_q == WW'(TRC_CLK - 1)) begin
          wait_d = '0;
          st_d   = (ref_q < RW'(AREF_NUM)) ? AREF_AREF : AREF_END;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      AREF_END: begin
        st_d  = AREF_IDLE;
        ref_d = '0;
      end
      default: st_d = AREF_IDLE;
    endcase
    unique case (1'b1)
      (st_d == AREF_PCHA): cmd_d = CMD_PRECHARGE;
      (st_d == AREF_AREF): cmd_d = CMD_AUTO_REF;
      default:             cmd_d = CMD_NOP;
    endcase
    end_d = (st_d == AREF_END);
  end

  assign bus.aref_req  = req_q;
  assign bus.aref_end  = end_q;
  assign bus.aref_cmd  = cmd_q;
  assign bus.aref_ba   = ALL_BANK_BA;
  assign bus.aref_addr = ALL_BANK_ADDR;

`ifdef SDRAM_AREF_MISS_CNT_EN
  logic [7:0] miss_q;

  // saturating count of intervals that elapsed while still waiting for a grant
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) miss_q <= '0;
    else if (wrap && req_q && miss_q != 8'hff)
      miss_q <= miss_q + 8'd1;
  end

  assign bus.aref_miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Bench for sdram_aref_ctrl: expected command events queued by stimulus,
// popped and compared by a monitor whenever the controller issues one.
`timescale 1ns/1ps
module tb_sdram_aref_ctrl;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] ENDK = 4'b1111;

  typedef struct {
    logic [3:0] kind;
    int         cyc;
  } ev_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic init_end = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];

  sdram_aref_ctrl_if bus();

  sdram_aref_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .init_end  (init_end),
    .bus       (bus.master)
  );

  always #3 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(int t);
    while (cyc < t) begin
      @(posedge sys_clk);
      #1;
    end
    if (cyc != t) chk("goto_overrun", cyc, t);
  endtask

  task automatic push(logic [3:0] k, int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // emulated arbiter grant starting in the current cycle
  task automatic grant(logic req_after);
    int  g;
    bit  seen;
    g = cyc;
    bus.aref_en = 1'b1;
    push(PRE,  g + 1);
    push(AREF, g + 5);
    push(AREF, g + 16);
    push(ENDK, g + 27);
    goto(g + 1);
    @(negedge sys_clk);
    chk("req_after_grant", bus.aref_req, req_after);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.aref_end) seen = 1'b1;
      else @(negedge sys_clk);
    end
    if (!seen) chk("aref_end_timeout", 0, 1);
    goto(cyc + 1);
    bus.aref_en = 1'b0;
  endtask

  // monitor: every non-NOP command or end pulse must match the queue head
  always @(negedge sys_clk) begin
    if (bus.aref_cmd !== NOP || bus.aref_end !== 1'b0) begin
      logic [3:0] k;
      k = bus.aref_end ? ENDK : bus.aref_cmd;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: kind %0h at cycle %0d, none expected", k, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("event_ba", bus.aref_ba, 2'b11);
        chk("event_addr", bus.aref_addr, 13'h1fff);
      end
    end
  end

  initial begin
    int c0;
    int gr;
    int r;
    bus.aref_en = 1'b0;

    goto(2);
    @(negedge sys_clk);
    chk("rst_req", bus.aref_req, 0);
    chk("rst_end", bus.aref_end, 0);
    chk("rst_cmd", bus.aref_cmd, NOP);
    chk("rst_ba", bus.aref_ba, 2'b11);
    chk("rst_addr", bus.aref_addr, 13'h1fff);
`ifdef SDRAM_AREF_MISS_CNT_EN
    chk("rst_miss", bus.aref_miss_cnt, 0);
`endif
    goto(5);
    sys_rst_n = 1'b1;

    for (int k = 1; k <= 10; k++) begin
      goto(5 + 500 * k);
      @(negedge sys_clk);
      chk("noinit_req", bus.aref_req, 0);
      chk("noinit_cmd", bus.aref_cmd, NOP);
      chk("noinit_addr", bus.aref_addr, 13'h1fff);
    end

    c0 = 5100;
    goto(c0);
    init_end = 1'b1;
    goto(c0 + 1249);
    @(negedge sys_clk);
    chk("req_before_wrap", bus.aref_req, 0);
    goto(c0 + 1250);
    @(negedge sys_clk);
    chk("req_at_wrap", bus.aref_req, 1);
    goto(c0 + 1252);
    grant(1'b0);
    goto(c0 + 1300);
    @(negedge sys_clk);
    chk("req_after_seq", bus.aref_req, 0);
    chk("queue_empty_1", exp_q.size(), 0);

    goto(c0 + 5001);
    @(negedge sys_clk);
    chk("req_starved", bus.aref_req, 1);
`ifdef SDRAM_AREF_MISS_CNT_EN
    chk("miss_starved", bus.aref_miss_cnt, 2);
`endif
    goto(c0 + 5010);
    grant(1'b0);
    goto(c0 + 5100);
    @(negedge sys_clk);
    chk("queue_empty_2", exp_q.size(), 0);
    chk("req_cleared_2", bus.aref_req, 0);

    goto(c0 + 7000);
    @(negedge sys_clk);
    chk("req_pending_3", bus.aref_req, 1);
    goto(c0 + 7499);
    grant(1'b1);
    goto(c0 + 7530);
    @(negedge sys_clk);
    chk("queue_empty_3", exp_q.size(), 0);
    chk("req_kept_3", bus.aref_req, 1);
`ifdef SDRAM_AREF_MISS_CNT_EN
    chk("miss_same_edge", bus.aref_miss_cnt, 3);
`endif

    gr = c0 + 7540;
    goto(gr);
    bus.aref_en = 1'b1;
    push(PRE, gr + 1);
    push(AREF, gr + 5);
    goto(gr + 8);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus.aref_req, 0);
    chk("mid_rst_cmd", bus.aref_cmd, NOP);
    chk("mid_rst_end", bus.aref_end, 0);
    chk("mid_rst_q", exp_q.size(), 0);
    bus.aref_en = 1'b0;
    r = gr + 10;
    goto(r);
    sys_rst_n = 1'b1;
    goto(r + 1249);
    @(negedge sys_clk);
    chk("restart_before_wrap", bus.aref_req, 0);
    goto(r + 1250);
    @(negedge sys_clk);
    chk("restart_wrap", bus.aref_req, 1);
`ifdef SDRAM_AREF_MISS_CNT_EN
    chk("miss_after_rst", bus.aref_miss_cnt, 0);
`endif
    goto(r + 1300);
    @(negedge sys_clk);
    chk("queue_empty_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_aref_ctrl.md
Name: sdram_aref_ctrl

Overview:
- Auto-refresh controller for the 167 MHz SDRAM path.
- Times the refresh interval after SDRAM initialisation and raises aref_req to the SDRAM arbiter.
- Once the arbiter grants with aref_en, issues the sequence PRECHARGE-all, then AREF_NUM × AUTO REFRESH, each with tRP/tRFC waits.
- Signals completion with aref_end; the arbiter muxes aref_cmd/aref_ba/aref_addr onto the pins while granted.

Parameters:
- CNT_REF_MAX, 1250: refresh interval in sys_clk cycles (7.5 us at 167 MHz; below 64 ms/8192 rows).
- TRP_CLK, 3: NOP cycles after PRECHARGE (tRP).
- TRC_CLK, 10: NOP cycles after each AUTO REFRESH (tRFC).
- AREF_NUM, 2: AUTO REFRESH commands per grant, 1..7.

Ports:
- sys_clk  in  1  system clock, 167 MHz.
- sys_rst_n  in  1  asynchronous reset, active-low.
- init_end  in  1  SDRAM init complete; sticky high.
- aref_en  in  1  grant from arbiter; high from grant until the cycle after aref_end.
- aref_req  out  1  refresh request to arbiter.
- aref_end  out  1  one-cycle pulse, sequence complete.
- aref_cmd  out  4  {cs_n,ras_n,cas_n,we_n}.
- aref_ba  out  2  bank address.
- aref_addr  out  13  address bus.
- aref_miss_cnt  out  8  present only with the optional feature.

Behaviour:
- Reset: sys_rst_n, asynchronous, active-low; clock sys_clk. All outputs registered.
- Reset values: aref_req=0, aref_end=0, aref_cmd=NOP 4'b0111, aref_ba=2'b11, aref_addr=13'h1fff; FSM in IDLE; all counters 0.
- Commands: NOP 0111, PRECHARGE 0010, AUTO_REF 0001.
- aref_ba=2'b11 and aref_addr=13'h1fff at all times; A10=1 selects all-bank precharge.
- Interval counter: held at 0 while init_end=0. Otherwise counts 0..CNT_REF_MAX-1 and wraps to 0; it free-runs and is not restarted by a grant.
- aref_req: set at the edge where the counter wraps. Cleared at the edge where FSM is IDLE and aref_en=1. Forced 0 while init_end=0.
- Simultaneous events: if wrap and clear occur on the same edge, set wins (a new interval has elapsed).
- FSM states: IDLE, PCHA, TRP, AREF, TRF, END. aref_cmd is registered together with the state, so it matches the state in the same cycle.
  - IDLE: cmd NOP. Go to PCHA when aref_en=1. Ignore aref_en while not IDLE.
  - PCHA: one cycle, cmd PRECHARGE. Go to TRP.
  - TRP: TRP_CLK cycles, cmd NOP. Go to AREF.
  - AREF: one cycle, cmd AUTO_REF, increment ref_cnt. Go to TRF.
  - TRF: TRC_CLK cycles, cmd NOP. Go to AREF if ref_cnt<AREF_NUM, else END.
  - END: one cycle, cmd NOP, aref_end=1, ref_cnt cleared. Go to IDLE.
- Latency with defaults: aref_en high at cycle 0; PRECHARGE in cycle 1; AUTO_REF in cycles 5 and 16; aref_end in cycle 27.
- Back-to-back grants: aref_en still high in END is ignored. Aref_en low in the IDLE cycle after END means no retrigger.
- A wrap during a sequence sets aref_req; it is serviced on the next grant.
- Reset mid-sequence: return to IDLE immediately with reset values; the partial sequence is abandoned.

Optional Feature:
- Macro: SDRAM_AREF_MISS_CNT_EN.
- Defined: aref_miss_cnt port exists. An 8-bit saturating counter increments when the counter wraps while aref_req is already 1, i.e. an interval starved by the arbiter. It holds at 255 and clears only on reset.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package/include sdram_defs: command encodings NOP/PRECHARGE/AUTO_REF/ACTIVE/READ/WRITE/LOAD_MODE, ALL_BANK_BA=2'b11, ALL_BANK_ADDR=13'h1fff.
- The arbiter and the init, write and read controllers also use sdram_defs.
- No sub-module; interval timer and FSM stay in one module.

Test Plan:
- Reset, init_end=0 for 5000 cycles -> aref_req stays 0; cmd=0111, ba=11, addr=1fff throughout.
- init_end rises at cycle 100, aref_en tied 0 -> aref_req rises at cycle 100+1250 and stays high.
- Grant 2 cycles after aref_req, emulating the arbiter (aref_en until cycle after aref_end):
  - aref_req drops the next cycle.
  - Command stream is PRECHARGE, 3×NOP, AUTO_REF, 10×NOP, AUTO_REF, 10×NOP, then aref_end pulse in cycle 27.
  - No second sequence follows.
- Grant withheld for 3×1250 cycles -> aref_req stays high; with SDRAM_AREF_MISS_CNT_EN, aref_miss_cnt=2. After the grant, exactly one sequence runs.
- sys_rst_n pulsed low during TRF of the first AUTO_REF -> outputs return to reset values asynchronously. After release with aref_en=0, FSM is IDLE and the interval restarts from 0.
- Wrap on the same edge as the grant (aref_en asserted at counter=CNT_REF_MAX-1) -> aref_req remains 1 after the edge and the sequence still starts.
